uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver (8N1, optional even parity) feeding the
//  control state machine. Oversamples rx_line, validates start/stop (and parity),
//  and presents each good byte on uart_rx with a 1-cycle recv strobe.
//  Sits between the board RX pin and the state machine's recv/uart_rx inputs.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  BAUD         115_200      line rate
//  OVERSAMPLE   16           ticks per bit; must be even, >=8
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset_     in   1  asynchronous, active-low reset
//  rx_line    in   1  raw serial input, idle high, asynchronous to clk
//  recv       out  1  1-cycle pulse: new valid byte on uart_rx
//  uart_rx    out  8  last valid byte; held until next valid byte
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  parity_err out  1  1-cycle pulse: parity mismatch (tied 0 without macro)
//  busy       out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//  - Reset: recv=0, uart_rx=8'h00, frame_err=0, parity_err=0, busy=0, state=IDLE,
//    synchronizer flops=1, tick/bit counters=0. Reset mid-frame abandons it silently.
//  - rx_line through 2-flop synchronizer (reset value 1); 2 clk input latency.
//  - Tick: 1-clk strobe every DIV=CLK_FREQ_HZ/(BAUD*OVERSAMPLE) clks; counter
//    restarts on start-bit detect so sampling is phase-aligned to the edge.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//    IDLE  : synced line low -> START, busy=1, tick_cnt=0.
//    START : at tick OVERSAMPLE/2-1 (mid-bit) line high -> IDLE (glitch, no
//            outputs); line low -> DATA, tick_cnt=0, bit_cnt=0.
//    DATA  : sample every OVERSAMPLE ticks at mid-bit, shift in LSB first;
//            after 8th bit -> PARITY (macro) or STOP.
//    PARITY: mid-bit sample; mismatch vs even parity of shift reg -> flag.
//    STOP  : mid-bit sample. High and no parity flag -> uart_rx<=shift reg,
//            recv=1 next clk, -> IDLE. High with parity flag -> parity_err=1,
//            uart_rx unchanged, -> IDLE. Low -> frame_err=1, uart_rx
//            unchanged, -> BREAK (frame_err wins over parity_err).
//    BREAK : wait until synced line high, then -> IDLE (no repeat flags).
//  - Returning to IDLE at stop mid-bit allows back-to-back frames with no gap.
//  - recv/frame_err/parity_err mutually exclusive, never asserted two cycles
//    in a row. busy=0 only in IDLE.
//  - Counters sized $clog2(DIV), $clog2(OVERSAMPLE), 4 bits for bit_cnt; no wrap
//    beyond terminal count.
// CONFIGURATION
//  UART_RX_PARITY_EN defined  : PARITY state present, 9th bit = even parity,
//                               parity_err driven as above.
//  UART_RX_PARITY_EN undefined: 8N1; DATA -> STOP directly; parity_err tied 0.
// STRUCTURE
//  uart_pkg: rx_state_t enum, DATA_BITS=8, default BAUD/OVERSAMPLE constants,
//  parity helper function. Sub-module uart_baud_tick (divider + restart input,
//  emits tick strobe); FSM, synchronizer and shift register stay in top.
// TESTING
//  Use CLK_FREQ_HZ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16 (DIV=1).
//  1 frame 0x2A -> single recv pulse ~10 bit-times after start edge, uart_rx=0x2A.
//  Back-to-back 0x45 then 0xDE, no idle gap -> two recv pulses 160 clk apart,
//    uart_rx=0x45 then 0xDE; busy stays high between frames.
//  Low glitch of 4 clk on idle line -> no recv/frame_err, busy drops, FSM IDLE.
//  Frame 0x11 with stop bit low, line held low 40 clk -> frame_err once,
//    no recv, uart_rx keeps previous value, next good frame 0x22 received.
//  reset_ low mid-DATA of 0xFF, release, then frame 0x5A -> no output from
//    aborted frame, all outputs at reset values, then recv with uart_rx=0x5A.
//  (macro) frame 0x03 with parity bit 1 -> parity_err pulse, no recv; with
//    parity bit 0 -> recv, uart_rx=0x03.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: state enum, frame width,
// default line settings and the even-parity helper.
package uart_pkg;

  localparam int DATA_BITS           = 8;
  localparam int DEFAULT_CLK_FREQ_HZ = 100_000_000;
  localparam int DEFAULT_BAUD        = 115_200;
  localparam int DEFAULT_OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Value the parity bit must carry so the data plus parity has an even number of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: serial input, received-byte outputs, status strobes
// and the FSM state for observation.
interface uart_receiver_if;
  import uart_pkg::*;

  // recv is a one-cycle valid strobe with no ready: the consumer must capture
  // uart_rx (or simply use it, since it holds) in the cycle recv is high.
  // frame_err and parity_err are one-cycle strobes, never together with recv.
  logic                 rx_line;
  logic                 recv;
  logic [DATA_BITS-1:0] uart_rx;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;
  rx_state_t            dbg_state;

  modport master (
    input  rx_line,
    output recv, uart_rx, frame_err, parity_err, busy, dbg_state
  );

  modport slave (
    output rx_line,
    input  recv, uart_rx, frame_err, parity_err, busy, dbg_state
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock strobe every DIV clocks, with a restart
// input that re-phases the count to the start-bit edge. DIV must be >= 1.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for an even parity
// bit between the data and the stop bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD        = DEFAULT_BAUD,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE
) (
  input  logic            clk,
  input  logic            reset_,
  uart_receiver_if.master bus
);

  localparam int DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = 4;

  localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx;
  logic                 w_tick;
  logic                 w_restart;

  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [TW-1:0]        r_tick_cnt;
  logic [TW-1:0]        w_tick_cnt_next;
  logic [BW-1:0]        r_bit_cnt;
  logic [BW-1:0]        w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_next;
  logic                 r_recv;
  logic                 w_recv_set;
  logic                 r_frame_err;
  logic                 w_frame_err_set;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 w_par_bad_next;
  logic                 r_parity_err;
  logic                 w_parity_err_set;
`endif

  // rx_line is asynchronous; reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_line;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk       (clk),
    .reset_    (reset_),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_recv      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tick_cnt  <= w_tick_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_recv      <= w_recv_set;
      r_frame_err <= w_frame_err_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bad    <= w_par_bad_next;
      r_parity_err <= w_parity_err_set;
    end
  end
`endif

  always_comb begin
    w_state_next     = r_state;
    w_tick_cnt_next  = r_tick_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_recv_set       = 1'b0;
    w_frame_err_set  = 1'b0;
    w_restart        = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_next   = r_par_bad;
    w_parity_err_set = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_state_next    = START;
          w_tick_cnt_next = '0;
          w_restart       = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_par_bad_next  = 1'b0;
`endif
        end
      end

      // Re-check the start bit at its middle to reject short low glitches.
      START: begin
        if (w_tick) begin
          if (r_tick_cnt == MID_START) begin
            w_tick_cnt_next = '0;
            if (w_rx) begin
              w_state_next   = IDLE;
            end else begin
              w_state_next   = DATA;
              w_bit_cnt_next = '0;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == BIT_END) begin
            w_tick_cnt_next = '0;
            w_shift_next    = {w_rx, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_next  = r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = PARITY;
`else
              w_state_next = STOP;
`endif
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          if (r_tick_cnt == BIT_END) begin
            w_tick_cnt_next = '0;
            w_par_bad_next  = (w_rx != even_parity(r_shift));
            w_state_next    = STOP;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
`endif

      // Leaving at the stop mid-bit leaves half a bit to catch a following start edge.
      STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == BIT_END) begin
            w_tick_cnt_next = '0;
            if (!w_rx) begin
              w_frame_err_set = 1'b1;
              w_state_next    = BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bad) begin
              w_parity_err_set = 1'b1;
              w_state_next     = IDLE;
`endif
            end else begin
              w_data_next  = r_shift;
              w_recv_set   = 1'b1;
              w_state_next = IDLE;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end

      BREAK: begin
        if (w_rx) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.recv      = r_recv;
  assign bus.uart_rx   = r_data;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus random traffic, scored against
// a frame-level model of what each transmitted frame must produce.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CLK_FREQ_HZ = 16_000_000;
  localparam int BAUD        = 1_000_000;
  localparam int OS          = 16;
  localparam int BIT_CLKS    = CLK_FREQ_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON  = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PARITY_ON  = 1'b0;
  localparam int FRAME_BITS = 10;
`endif

  localparam logic [1:0] EV_RECV = 2'd1;
  localparam logic [1:0] EV_FERR = 2'd2;
  localparam logic [1:0] EV_PERR = 2'd3;

  logic clk    = 1'b0;
  logic reset_ = 1'b0;

  always #5 clk = ~clk;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (OS)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  int         start_q[$];
  logic [7:0] last_good = 8'h00;
  int         recv_t_prev = -1;
  int         recv_t_last = -1;
  logic       prev_strobe = 1'b0;
  logic [7:0] d;
  logic       sb;
  logic       pb;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    int         n_hot;
    int         lat;
    int         st;
    logic [1:0] code;
    logic [9:0] e;
    if (!reset_) begin
      prev_strobe = 1'b0;
    end else begin
      n_hot = int'(bus.recv) + int'(bus.frame_err) + int'(bus.parity_err);
      if (n_hot != 0) begin
        check_eq("one_hot", n_hot, 1);
        check_eq("no_repeat", prev_strobe, 0);
        code = bus.recv ? EV_RECV : (bus.frame_err ? EV_FERR : EV_PERR);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_evt", code, 0);
        end else begin
          e  = exp_q.pop_front();
          st = start_q.pop_front();
          check_eq("evt_kind", code, e[9:8]);
          lat = cyc - st;
          check_eq("latency_ok",
                   (lat >= (FRAME_BITS - 1) * BIT_CLKS) && (lat <= FRAME_BITS * BIT_CLKS), 1);
          if (code == EV_RECV) begin
            check_eq("uart_rx", bus.uart_rx, e[7:0]);
            last_good   = e[7:0];
            recv_t_prev = recv_t_last;
            recv_t_last = cyc;
          end else begin
            check_eq("uart_rx_hold", bus.uart_rx, last_good);
          end
        end
      end
      prev_strobe = (n_hot != 0);
    end
  end

  task automatic drive_bit(input logic b);
    bus.rx_line = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_line = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] dat, input logic stop_b, input logic par_b);
    logic [1:0] kind;
    kind = EV_RECV;
    if (PARITY_ON && (par_b != ^dat)) kind = EV_PERR;
    if (!stop_b) kind = EV_FERR;
    exp_q.push_back({kind, dat});
    start_q.push_back(cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.rx_line = dat[i];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        check_eq("busy_mid", bus.busy, 1);
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
      end else begin
        drive_bit(dat[i]);
      end
    end
    if (PARITY_ON) drive_bit(par_b);
    drive_bit(stop_b);
  endtask

  task automatic wait_drain(input int max_clks);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_clks) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset_      = 1'b0;
    bus.rx_line = 1'b1;
    exp_q.delete();
    start_q.delete();
    last_good = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_recv", bus.recv, 0);
    check_eq("rst_uart_rx", bus.uart_rx, 8'h00);
    check_eq("rst_frame_err", bus.frame_err, 0);
    check_eq("rst_parity_err", bus.parity_err, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    reset_ = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("busy_after_rst", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_line = 1'b1;
    reset_      = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();
    idle(20);

    send_frame(8'h2A, 1'b1, ^8'h2A);
    idle(20);
    wait_drain(400);
    check_eq("rx_2a", bus.uart_rx, 8'h2A);

    send_frame(8'h45, 1'b1, ^8'h45);
    send_frame(8'hDE, 1'b1, ^8'hDE);
    idle(20);
    wait_drain(400);
    check_eq("b2b_spacing", recv_t_last - recv_t_prev, FRAME_BITS * BIT_CLKS);
    check_eq("rx_de", bus.uart_rx, 8'hDE);

    // Short low glitch on an idle line.
    bus.rx_line = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.rx_line = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("glitch_busy", bus.busy, 1);
    repeat (30) @(posedge clk);
    #1;
    check_eq("glitch_idle_busy", bus.busy, 0);
    check_eq("glitch_idle_state", 32'(bus.dbg_state), 32'(IDLE));

    // Missing stop bit, line held low 40 clocks from the stop bit on.
    send_frame(8'h11, 1'b0, ^8'h11);
    repeat (40 - BIT_CLKS) @(posedge clk);
    #1;
    check_eq("break_state", 32'(bus.dbg_state), 32'(BREAK));
    idle(32);
    check_eq("break_exit", 32'(bus.dbg_state), 32'(IDLE));
    wait_drain(400);
    check_eq("ferr_hold", bus.uart_rx, 8'hDE);
    send_frame(8'h22, 1'b1, ^8'h22);
    idle(20);
    wait_drain(400);
    check_eq("rx_22", bus.uart_rx, 8'h22);

    // Reset in the middle of the data bits of 0xFF.
    bus.rx_line = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    bus.rx_line = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    apply_reset();
    idle(40);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(20);
    wait_drain(400);
    check_eq("rx_5a", bus.uart_rx, 8'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle(20);
    wait_drain(400);
    check_eq("perr_hold", bus.uart_rx, 8'h5A);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(20);
    wait_drain(400);
    check_eq("rx_03", bus.uart_rx, 8'h03);
`endif

    for (int k = 0; k < 30; k++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 7) != 0);
      pb = (^d) ^ ($urandom_range(0, 4) == 0);
      send_frame(d, sb, pb);
      if (!sb) idle($urandom_range(16, 30));
      else     idle($urandom_range(0, 20));
    end
    idle(20);
    wait_drain(400);
    check_eq("final_busy", bus.busy, 0);
    check_eq("final_state", 32'(bus.dbg_state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
